// File: rtl/alu_pkg.sv
// Shared ALU definitions: adder result width and the accumulator FSM state type.
package alu_pkg;

   localparam int ALU_SUM_W = 8;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

endpackage

// File: rtl/alu_sum_accumulator_if.sv
// Handshake bundle between the adder, the sum accumulator and its consumer.
interface alu_sum_accumulator_if
   import alu_pkg::*;
#(
   parameter int IN_W  = ALU_SUM_W,
   parameter int ACC_W = 10
);

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  sum_in;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic             overflow;

   // master: drives sums in and takes results out
   modport master (
      output in_valid, sum_in, out_ready,
      input  in_ready, out_valid, acc_out, overflow
   );

   modport slave (
      input  in_valid, sum_in, out_ready,
      output in_ready, out_valid, acc_out, overflow
   );

endinterface

// File: rtl/alu_sum_accumulator.sv
// Accumulates batches of COUNT unsigned adder sums and presents each batch total
// with a sticky overflow flag on a valid/ready output.
module alu_sum_accumulator
   import alu_pkg::*;
#(
   parameter int IN_W  = ALU_SUM_W,
   parameter int ACC_W = 10,
   parameter int COUNT = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   alu_sum_accumulator_if.slave  bus
);

   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   acc_state_t       state_r, state_s;
   logic [ACC_W-1:0] acc_r,   acc_s;
   logic [CNT_W-1:0] cnt_r,   cnt_s;
   logic             ovf_r,   ovf_s;
   logic [ACC_W:0]   add_s;
   logic             accept_s;

   // carry out of the ACC_W-bit add lands in the top bit
   assign add_s    = {1'b0, acc_r} + {1'b0, ACC_W'(bus.sum_in)};
   assign accept_s = bus.in_valid && (state_r == ACCUM);

   // next-state, accumulator, counter and overflow update; clear overrides everything
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      cnt_s   = cnt_r;
      ovf_s   = ovf_r;
      case (state_r)
         ACCUM: begin
            if (accept_s) begin
               acc_s = add_s[ACC_W-1:0];
               ovf_s = ovf_r | add_s[ACC_W];
               if (cnt_r == CNT_LAST) begin
                  cnt_s   = {CNT_W{1'b0}};
                  state_s = HOLD;
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               state_s = ACCUM;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_s = ACCUM;
               acc_s   = {ACC_W{1'b0}};
               ovf_s   = 1'b0;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = ACCUM;
            acc_s   = {ACC_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
            ovf_s   = 1'b0;
         end
      endcase
      if (clear) begin
         state_s = ACCUM;
         acc_s   = {ACC_W{1'b0}};
         cnt_s   = {CNT_W{1'b0}};
         ovf_s   = 1'b0;
      end else begin
         state_s = state_s;
      end
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ACCUM;
         acc_r   <= {ACC_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         acc_r   <= acc_s;
         cnt_r   <= cnt_s;
         ovf_r   <= ovf_s;
      end
   end

   // handshake outputs depend on the state register only
   assign bus.in_ready  = (state_r == ACCUM);
   assign bus.out_valid = (state_r == HOLD);
   assign bus.acc_out   = acc_r;
   assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_alu_sum_accumulator.sv
// Randomized and directed bench for alu_sum_accumulator against a batch-level reference model.
module tb_alu_sum_accumulator;

   logic clk = 1'b0;
   logic rst_n_a, rst_n_b, clr_a, clr_b;
   logic model_on = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   // reference model state per instance (0: ACC_W=10/COUNT=4, 1: ACC_W=8/COUNT=2)
   int m_sum[2];
   int m_n[2];
   bit m_hold[2];
   int m_total[2];
   int m_ovf[2];
   int m_batches[2];

   always #5 clk = ~clk;

   alu_sum_accumulator_if #(.IN_W(8), .ACC_W(10)) ifa ();
   alu_sum_accumulator_if #(.IN_W(8), .ACC_W(8))  ifb ();

   alu_sum_accumulator #(.IN_W(8), .ACC_W(10), .COUNT(4)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .clear(clr_a), .bus(ifa)
   );

   alu_sum_accumulator #(.IN_W(8), .ACC_W(8), .COUNT(2)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .clear(clr_b), .bus(ifb)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // batch semantics: collect cnt sums, then hold the true total until taken
   task automatic model_step(input int k, input int cnt, input int w, input bit rst,
                             input bit clr, input bit v, input int s, input bit r);
      if (!rst || clr) begin
         m_sum[k] = 0; m_n[k] = 0; m_hold[k] = 1'b0;
      end else if (m_hold[k]) begin
         if (r) begin
            m_hold[k] = 1'b0; m_sum[k] = 0; m_n[k] = 0;
            m_batches[k]++;
         end
      end else if (v) begin
         m_sum[k] += s;
         m_n[k]++;
         if (m_n[k] == cnt) begin
            m_hold[k]  = 1'b1;
            m_total[k] = m_sum[k] % (1 << w);
            m_ovf[k]   = (m_sum[k] >= (1 << w)) ? 1 : 0;
            m_n[k]     = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0, 4, 10, rst_n_a, clr_a, ifa.in_valid, int'(ifa.sum_in), ifa.out_ready);
      model_step(1, 2, 8,  rst_n_b, clr_b, ifb.in_valid, int'(ifb.sum_in), ifb.out_ready);
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("a_in_ready",  int'(ifa.in_ready),  m_hold[0] ? 0 : 1);
         chk("a_out_valid", int'(ifa.out_valid), m_hold[0] ? 1 : 0);
         if (m_hold[0]) begin
            chk("a_acc_out",  int'(ifa.acc_out),  m_total[0]);
            chk("a_overflow", int'(ifa.overflow), m_ovf[0]);
         end
         chk("b_in_ready",  int'(ifb.in_ready),  m_hold[1] ? 0 : 1);
         chk("b_out_valid", int'(ifb.out_valid), m_hold[1] ? 1 : 0);
         if (m_hold[1]) begin
            chk("b_acc_out",  int'(ifb.acc_out),  m_total[1]);
            chk("b_overflow", int'(ifb.overflow), m_ovf[1]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_a(input int s);
      ifa.in_valid = 1'b1;
      ifa.sum_in   = 8'(s);
      cyc();
   endtask

   task automatic feed_b(input int s);
      ifb.in_valid = 1'b1;
      ifb.sum_in   = 8'(s);
      cyc();
   endtask

   initial begin
      int start;
      int cycles;
      bit took_a, took_b;
      rst_n_a = 1'b0; rst_n_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      ifa.in_valid = 1'b0; ifa.sum_in = 8'd0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.sum_in = 8'd0; ifb.out_ready = 1'b0;
      cyc();
      cyc();
      model_on = 1'b1;
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      chk("rst_in_ready",  int'(ifa.in_ready),  1);
      chk("rst_out_valid", int'(ifa.out_valid), 0);
      chk("rst_acc_out",   int'(ifa.acc_out),   0);
      chk("rst_overflow",  int'(ifa.overflow),  0);

      // 10+20+30+40 with the consumer always ready
      ifa.out_ready = 1'b1;
      feed_a(10); feed_a(20); feed_a(30);
      chk("t1_not_done", int'(ifa.out_valid), 0);
      feed_a(40);
      ifa.in_valid = 1'b0;
      chk("t1_out_valid", int'(ifa.out_valid), 1);
      chk("t1_in_ready",  int'(ifa.in_ready),  0);
      chk("t1_acc",       int'(ifa.acc_out),   100);
      chk("t1_ovf",       int'(ifa.overflow),  0);
      chk("t1_model",     m_total[0],          100);
      cyc();
      chk("t1_back_ready", int'(ifa.in_ready),  1);
      chk("t1_back_valid", int'(ifa.out_valid), 0);

      // consumer stalls while upstream keeps offering a sum
      ifa.out_ready = 1'b0;
      feed_a(5); feed_a(5); feed_a(5); feed_a(5);
      ifa.sum_in = 8'd6;
      for (int i = 0; i < 5; i++) begin
         chk("t3_in_ready", int'(ifa.in_ready), 0);
         chk("t3_acc",      int'(ifa.acc_out),  20);
         cyc();
      end
      ifa.out_ready = 1'b1;
      cyc();
      chk("t3_release", int'(ifa.in_ready), 1);
      cyc();
      feed_a(1); feed_a(1); feed_a(1);
      ifa.in_valid = 1'b0;
      chk("t3_next_acc", int'(ifa.acc_out), 9);
      cyc();

      // clear drops the coincident sum and the partial batch
      feed_a(7); feed_a(7);
      ifa.in_valid = 1'b1; ifa.sum_in = 8'd9; clr_a = 1'b1;
      cyc();
      clr_a = 1'b0;
      chk("t4_clr_acc", int'(ifa.acc_out), 0);
      feed_a(1); feed_a(1); feed_a(1); feed_a(1);
      ifa.in_valid = 1'b0;
      chk("t4_valid", int'(ifa.out_valid), 1);
      chk("t4_acc",   int'(ifa.acc_out),   4);

      // reset in HOLD wins over a ready consumer
      start = m_batches[0];
      rst_n_a = 1'b0; ifa.out_ready = 1'b1;
      cyc();
      rst_n_a = 1'b1;
      chk("t5_out_valid", int'(ifa.out_valid), 0);
      chk("t5_acc",       int'(ifa.acc_out),   0);
      chk("t5_ovf",       int'(ifa.overflow),  0);
      chk("t5_in_ready",  int'(ifa.in_ready),  1);
      chk("t5_no_hs",     m_batches[0] - start, 0);

      // narrow accumulator wraps and flags overflow, next batch is clean
      ifb.out_ready = 1'b1;
      feed_b(200); feed_b(100);
      ifb.in_valid = 1'b0;
      chk("t2_acc", int'(ifb.acc_out),  44);
      chk("t2_ovf", int'(ifb.overflow), 1);
      cyc();
      feed_b(1); feed_b(2);
      ifb.in_valid = 1'b0;
      chk("t2b_acc", int'(ifb.acc_out),  3);
      chk("t2b_ovf", int'(ifb.overflow), 0);
      cyc();

      // random stalls; upstream holds its sum until accepted
      start  = m_batches[0];
      cycles = 0;
      took_a = 1'b0;
      took_b = 1'b0;
      while ((m_batches[0] - start) < 1000 && cycles < 30000) begin
         if (!ifa.in_valid || took_a) begin
            ifa.in_valid = ($urandom_range(3) != 0);
            ifa.sum_in   = 8'($urandom_range(255));
         end
         if (!ifb.in_valid || took_b) begin
            ifb.in_valid = ($urandom_range(3) != 0);
            ifb.sum_in   = 8'($urandom_range(255));
         end
         ifa.out_ready = 1'($urandom_range(1));
         ifb.out_ready = 1'($urandom_range(1));
         clr_a = ($urandom_range(299) == 0);
         clr_b = ($urandom_range(299) == 0);
         took_a = ifa.in_valid && ifa.in_ready;
         took_b = ifb.in_valid && ifb.in_ready;
         cyc();
         cycles++;
      end
      chk("rand_batches_done", ((m_batches[0] - start) >= 1000) ? 1 : 0, 1);

      clr_a = 1'b0; clr_b = 1'b0;
      ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
      cyc();
      cyc();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
